uop_sequencer: RTL
==================

Name: uop_sequencer

Overview:
- Microcode sequencer that sits directly downstream of the curve microprogram ROMs (doubling, addition, conversion).
- Drives the ROM address and consumes the registered 20-bit micro-op word one cycle later.
- Decodes each micro-op and evaluates its execution condition. Issues a one-cycle start strobe to the selected arithmetic unit and waits for that unit's ready before fetching the next word.
- Holds the compare flag that conditional micro-ops test; signals completion when the program reaches OPCODE_RDY.

Parameters:
ADDR_W, 6, ROM address width
UOP_W, 20, micro-op word width (fixed field map below; only 20 supported)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  start request, level-sampled in IDLE
rdy  out  1  high when idle/finished, low while a program runs
uop_addr  out  ADDR_W  ROM address
uop_data  in  UOP_W  ROM word, valid one cycle after uop_addr changes
unit_ena  out  5  one-hot start strobe: [0] CMP, [1] MOV, [2] MUL, [3] ADD, [4] SUB
unit_rdy  in  5  per-unit ready; high = idle/finished
sel_src_a  out  5  operand A selector, from the micro-op
sel_src_b  out  5  operand B selector, from the micro-op
sel_dst  out  4  destination selector, from the micro-op
cmp_eq  in  1  compare result from the CMP unit, valid when unit_rdy[0] rises

Behaviour:
- Field map: opcode [19:16], src_a [15:11], src_b [10:6], dst [5:2], exec [1:0].
- Opcodes: 0 RDY, 1 CMP, 2 MOV, 3 MUL, 4 ADD, 5 SUB. Codes 6..15 are NOP.
- Exec codes: 00 ALWAYS; 01 execute if flag=1 (PZT1T2_0XX); 10 execute if flag=0; 11 never.
- Reset values: rdy=1, uop_addr=0, unit_ena=0, sel_* = 0, state=IDLE, flag=0.
- IDLE: rdy=1, uop_addr held at 0.
  - ena=1 → clear flag, rdy←0, go to FETCH.
  - ena is ignored in all other states.
- FETCH: one cycle wait for ROM latency, then go to DECODE.
- DECODE: sample uop_data.
  - RDY opcode → go to IDLE, rdy←1, uop_addr←0.
  - Condition false, or NOP opcode → uop_addr+1, go to FETCH.
  - Otherwise → register sel_src_a/sel_src_b/sel_dst from the word, go to TRIGGER.
- TRIGGER: unit_ena one-hot bit high for exactly one cycle; sel_* stable; go to WAIT.
- WAIT: sel_* held stable.
  - From the cycle after TRIGGER, wait for unit_rdy[k]=1.
  - Then: if CMP, flag←cmp_eq; uop_addr+1; go to FETCH.
- Minimum cost per word:
  - Executed micro-op: 4 cycles + unit busy time.
  - Skipped micro-op: 2 cycles.
- Address end: if DECODE at uop_addr = 2^ADDR_W−1 would increment, treat as RDY (go to IDLE, rdy←1, uop_addr←0). No wrap-around.
- sel_* hold the last executed values when idle.
- The flag persists between micro-ops and is cleared only at program start and at reset.
- rst_n low at any time, including mid-WAIT: all outputs return to reset values immediately. A pending unit_ena pulse is aborted.
- ena held high through completion: a new program starts on the cycle after rdy returns to 1.

Test Plan:
1. Reset mid-run: assert rst_n=0 during WAIT of a MUL → unit_ena=0, rdy=1, uop_addr=0 asynchronously; sequencer stays IDLE after release with ena=0.
2. Conversion program with PZ≠0: ROM holds CMP, MOV, MUL×4, MOV/EXEC=01 ×2, RDY at 8. CMP unit returns cmp_eq=0 → unit_ena pulses in order 1,2,4,4,4,4; both conditional MOVs are skipped (no pulse); rdy rises after DECODE of address 8.
3. Same program with cmp_eq=1 → eight strobes in sequence, the last two on bit 1 (MOV) with sel_src_a set to the ZERO code; rdy=1 afterwards.
4. Unit stall: MUL unit_rdy held low 50 cycles after its strobe → uop_addr and sel_* unchanged for the full 50 cycles; exactly one strobe; advance on the cycle unit_rdy returns high.
5. Addressing edges: word 0 = RDY → rdy low for exactly 2 cycles. ROM filled with NOPs → sequencer ends at address 63 with rdy=1 and uop_addr=0; no unit_ena ever.
6. ena held high continuously → back-to-back programs; flag cleared at each restart (conditional MOV skipped in run 2 when its CMP returns 0).

Source files
------------

// File: rtl/uop_sequencer.sv
// ---------------------------------------------------------------------------
// uop_sequencer
//
// Microcode sequencer sitting behind the curve microprogram ROMs. It walks
// the ROM address, decodes each registered 20-bit micro-op, evaluates its
// execution condition against the compare flag, fires a one-cycle start
// strobe at the selected arithmetic unit and waits for that unit to finish
// before fetching the next word. A program ends on an RDY opcode or when the
// last ROM address would be stepped past.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        start request, sampled only while idle
//   rdy        high when idle/finished, low while a program runs
//   uop_addr   ROM address
//   uop_data   ROM word, valid one cycle after uop_addr changes
//   unit_ena   one-hot start strobe: [0] CMP [1] MOV [2] MUL [3] ADD [4] SUB
//   unit_rdy   per-unit ready, high = idle/finished
//   sel_src_a  operand A selector from the executing micro-op
//   sel_src_b  operand B selector from the executing micro-op
//   sel_dst    destination selector from the executing micro-op
//   cmp_eq     compare result, valid when unit_rdy[0] rises
// ---------------------------------------------------------------------------
module uop_sequencer #(
    parameter int ADDR_W = 6,
    parameter int UOP_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    output logic              rdy,
    output logic [ADDR_W-1:0] uop_addr,
    input  logic [UOP_W-1:0]  uop_data,
    output logic [4:0]        unit_ena,
    input  logic [4:0]        unit_rdy,
    output logic [4:0]        sel_src_a,
    output logic [4:0]        sel_src_b,
    output logic [3:0]        sel_dst,
    input  logic              cmp_eq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_TRIGGER,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              rdy_q, rdy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        unitSel_q, unitSel_d;
    logic [4:0]        selA_q, selA_d;
    logic [4:0]        selB_q, selB_d;
    logic [3:0]        dst_q, dst_d;
    logic              flag_q, flag_d;

    logic [3:0] opcode;
    logic [1:0] execCode;
    logic       condOk;
    logic [4:0] opUnit;
    logic       lastAddr;

    assign opcode   = uop_data[19:16];
    assign execCode = uop_data[1:0];
    assign lastAddr = (addr_q == {ADDR_W{1'b1}});

    // Execution condition against the compare flag.
    always_comb begin
        condOk = 1'b0;
        case (execCode)
            2'b00:   condOk = 1'b1;
            2'b01:   condOk = flag_q;
            2'b10:   condOk = ~flag_q;
            default: condOk = 1'b0;
        endcase
    end

    // Opcode to unit strobe; zero means RDY or NOP (no unit).
    always_comb begin
        opUnit = 5'b00000;
        case (opcode)
            4'd1:    opUnit = 5'b00001;
            4'd2:    opUnit = 5'b00010;
            4'd3:    opUnit = 5'b00100;
            4'd4:    opUnit = 5'b01000;
            4'd5:    opUnit = 5'b10000;
            default: opUnit = 5'b00000;
        endcase
    end

    // Next-state logic. Stepping past the last ROM address ends the program
    // instead of wrapping, both for skipped and executed micro-ops.
    always_comb begin
        state_d   = state_q;
        rdy_d     = rdy_q;
        addr_d    = addr_q;
        unitSel_d = unitSel_q;
        selA_d    = selA_q;
        selB_d    = selB_q;
        dst_d     = dst_q;
        flag_d    = flag_q;
        case (state_q)
            S_IDLE: begin
                if (ena) begin
                    flag_d  = 1'b0;
                    rdy_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == 4'd0) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                    addr_d  = '0;
                end else if (!condOk || (opUnit == 5'b00000)) begin
                    if (lastAddr) begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b1;
                        addr_d  = '0;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    unitSel_d = opUnit;
                    selA_d    = uop_data[15:11];
                    selB_d    = uop_data[10:6];
                    dst_d     = uop_data[5:2];
                    state_d   = S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if ((unit_rdy & unitSel_q) != 5'b00000) begin
                    if (unitSel_q[0]) begin
                        flag_d = cmp_eq;
                    end
                    if (lastAddr) begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b1;
                        addr_d  = '0;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
                addr_d  = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rdy_q     <= 1'b1;
            addr_q    <= '0;
            unitSel_q <= 5'b00000;
            selA_q    <= 5'b00000;
            selB_q    <= 5'b00000;
            dst_q     <= 4'b0000;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            addr_q    <= addr_d;
            unitSel_q <= unitSel_d;
            selA_q    <= selA_d;
            selB_q    <= selB_d;
            dst_q     <= dst_d;
            flag_q    <= flag_d;
        end
    end

    // The strobe is decoded from the state register so that a reset drops
    // it immediately, aborting a pending pulse.
    assign unit_ena  = (state_q == S_TRIGGER) ? unitSel_q : 5'b00000;
    assign rdy       = rdy_q;
    assign uop_addr  = addr_q;
    assign sel_src_a = selA_q;
    assign sel_src_b = selB_q;
    assign sel_dst   = dst_q;

endmodule
